// File: rtl/pio_mem_sequencer_pkg.sv
// Shared definitions for the PIO-driven SRAM access sequencer:
// FSM state encoding, cmd_in bit positions and status_out bit positions.
package pio_mem_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    // cmd_in layout as written by firmware
    localparam int CMD_W   = 3;
    localparam int CMD_GO  = 0;
    localparam int CMD_WR  = 1;
    localparam int CMD_PTR = 2;

    // status_out layout, read back by firmware as {done, busy}
    localparam int ST_W    = 2;
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;

    // Load value for the ACCESS down-counter; the phase ends when it reaches zero
    function automatic logic [3:0] access_load(input int wait_states);
        return 4'(wait_states - 1);
    endfunction

endpackage

// File: rtl/pio_mem_sequencer_if.sv
// Bundle of the PIO-facing and SRAM-facing signals of the sequencer.
// The slave modport is the sequencer's view; the master modport is the
// view of the firmware PIOs together with the SRAM device.
interface pio_mem_sequencer_if #(
    parameter int AW = 16,
    parameter int DW = 16
) ();
    import pio_mem_pkg::*;

    logic [AW-1:0]    addr_in;
    logic [DW-1:0]    wdata_in;
    logic [CMD_W-1:0] cmd_in;
    logic [DW-1:0]    rdata_out;
    logic [ST_W-1:0]  status_out;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic             mem_cs_n;
    logic             mem_we_n;
    logic             mem_oe_n;

    modport slave (
        input  addr_in, wdata_in, cmd_in, mem_rdata,
        output rdata_out, status_out, mem_addr, mem_wdata,
               mem_cs_n, mem_we_n, mem_oe_n
    );

    modport master (
        output addr_in, wdata_in, cmd_in, mem_rdata,
        input  rdata_out, status_out, mem_addr, mem_wdata,
               mem_cs_n, mem_we_n, mem_oe_n
    );

endinterface

// File: rtl/pio_mem_sequencer_edge_sync.sv
// Registers the command PIO once and turns the go bit into a single-cycle
// pulse on its 0->1 transition. A go level held high never retriggers.
module pio_edge_sync
    import pio_mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CMD_W-1:0] cmd_in,
    output logic             go_edge,
    output logic             cmd_wr,
    output logic             cmd_ptr
);

    logic [CMD_W-1:0] cmd_q;
    logic             go_prev;

    // Capture the PIO command word and remember the previous go level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q   <= '0;
            go_prev <= 1'b0;
        end else begin
            cmd_q   <= cmd_in;
            go_prev <= cmd_q[CMD_GO];
        end
    end

    assign go_edge = cmd_q[CMD_GO] & ~go_prev;
    assign cmd_wr  = cmd_q[CMD_WR];
    assign cmd_ptr = cmd_q[CMD_PTR];

endmodule

// File: rtl/pio_mem_sequencer.sv
// PIO-driven SRAM access sequencer. A rising go bit from firmware starts one
// timed read or write: SETUP (1 clk), ACCESS (WAIT_STATES clks), HOLD (1 clk),
// DONE (1 clk). Read data and {done, busy} are returned for polling.
// Optional feature: define PIO_MEM_AUTOINC_EN to add an auto-incrementing
// address pointer selected by cmd_in[2].
module pio_mem_sequencer
    import pio_mem_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 16,
    // Cycles the strobe stays active; legal range 1..15
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_mem_sequencer_if.slave   bus
);

    seq_state_t    state, state_nxt;
    logic [3:0]    wait_cnt, wait_cnt_nxt;
    logic          busy_q, busy_nxt;
    logic          done_q, done_nxt;
    logic          latch_req;
    logic          rdata_load;
    logic          cs_n, we_n, oe_n;

    logic [AW-1:0] addr_lat;
    logic [DW-1:0] wdata_lat;
    logic          wr_lat;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] sel_addr;

    logic          go_edge;
    logic          cmd_wr;
    logic          cmd_ptr;

    pio_edge_sync u_edge_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .cmd_in  (bus.cmd_in),
        .go_edge (go_edge),
        .cmd_wr  (cmd_wr),
        .cmd_ptr (cmd_ptr)
    );

`ifdef PIO_MEM_AUTOINC_EN
    logic [AW-1:0] ptr;

    // Pointer follows the last completed access so the next ptr access lands one higher
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (state == DONE) begin
            ptr <= addr_lat + AW'(1);
        end
    end

    assign sel_addr = cmd_ptr ? ptr : bus.addr_in;
`else
    logic ptr_unused;

    assign ptr_unused = cmd_ptr;
    assign sel_addr   = bus.addr_in;
`endif

    // State and ACCESS wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next state, strobes and status updates; go in any busy state is dropped
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        busy_nxt     = busy_q;
        done_nxt     = done_q;
        latch_req    = 1'b0;
        rdata_load   = 1'b0;
        cs_n         = 1'b1;
        we_n         = 1'b1;
        oe_n         = 1'b1;

        case (state)
            IDLE: begin
                if (go_edge) begin
                    latch_req = 1'b1;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cs_n         = 1'b0;
                wait_cnt_nxt = access_load(WAIT_STATES);
                state_nxt    = ACCESS;
            end
            ACCESS: begin
                cs_n = 1'b0;
                we_n = ~wr_lat;
                oe_n = wr_lat;
                if (wait_cnt == '0) begin
                    rdata_load = ~wr_lat;
                    state_nxt  = HOLD;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            HOLD: begin
                cs_n      = 1'b0;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, read-data capture and status bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_lat  <= '0;
            wdata_lat <= '0;
            wr_lat    <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (latch_req) begin
                addr_lat  <= sel_addr;
                wdata_lat <= bus.wdata_in;
                wr_lat    <= cmd_wr;
            end
            if (rdata_load) begin
                rdata_q <= bus.mem_rdata;
            end
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    assign bus.mem_addr            = addr_lat;
    assign bus.mem_wdata           = wdata_lat;
    assign bus.mem_cs_n            = cs_n;
    assign bus.mem_we_n            = we_n;
    assign bus.mem_oe_n            = oe_n;
    assign bus.rdata_out           = rdata_q;
    assign bus.status_out[ST_BUSY] = busy_q;
    assign bus.status_out[ST_DONE] = done_q;

endmodule

// File: tb/tb_pio_mem_sequencer.sv
// Directed testbench for pio_mem_sequencer with a simple SRAM model.
// Unwritten SRAM locations read back as address ^ 16'h5A5A.
module tb_pio_mem_sequencer;
    import pio_mem_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int WS = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    pio_mem_sequencer_if #(.AW(AW), .DW(DW)) bus ();

    pio_mem_sequencer #(.AW(AW), .DW(DW), .WAIT_STATES(WS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [DW-1:0] sram [0:65535];
    bit            wr_flag [0:65535];

    // SRAM write port: writes on every clock where cs_n and we_n are both low
    always @(posedge clk) begin
        if (!bus.mem_cs_n && !bus.mem_we_n) begin
            sram[bus.mem_addr]    <= bus.mem_wdata;
            wr_flag[bus.mem_addr] <= 1'b1;
        end
    end

    assign bus.mem_rdata = wr_flag[bus.mem_addr] ? sram[bus.mem_addr] : (bus.mem_addr ^ 16'h5A5A);

    int   checks = 0;
    int   fails = 0;
    int   we_low_cnt = 0;
    int   oe_low_cnt = 0;
    int   cs_fall_cnt = 0;
    int   done_rise_cnt = 0;
    int   both_cnt = 0;
    logic cs_prev = 1'b1;
    logic done_prev = 1'b0;

    // Activity monitor sampled on the inactive edge
    always @(negedge clk) begin
        if (!bus.mem_we_n) we_low_cnt++;
        if (!bus.mem_oe_n) oe_low_cnt++;
        if (cs_prev && !bus.mem_cs_n) cs_fall_cnt++;
        if (!done_prev && bus.status_out[ST_DONE]) done_rise_cnt++;
        if (bus.status_out[ST_DONE] && bus.status_out[ST_BUSY]) both_cnt++;
        cs_prev   = bus.mem_cs_n;
        done_prev = bus.status_out[ST_DONE];
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] w, input logic [2:0] c);
        @(negedge clk);
        bus.addr_in  = a;
        bus.wdata_in = w;
        bus.cmd_in   = c;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.mem_cs_n, bus.mem_we_n, bus.mem_oe_n} !== 3'b111) begin
            fails++;
            $display("[TB] FAIL reset_ctl: got %b, expected 111", {bus.mem_cs_n, bus.mem_we_n, bus.mem_oe_n});
        end
        checks++;
        if (bus.status_out !== 2'b00) begin
            fails++;
            $display("[TB] FAIL reset_status: got %b, expected 00", bus.status_out);
        end
        checks++;
        if ({bus.rdata_out, bus.mem_addr, bus.mem_wdata} !== 48'h0) begin
            fails++;
            $display("[TB] FAIL reset_data: got %h, expected 0", {bus.rdata_out, bus.mem_addr, bus.mem_wdata});
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_cs_n, bus.status_out} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: got %b, expected 100", {bus.mem_cs_n, bus.status_out});
        end
    endtask

    task automatic test_write();
        logic [2:0] exp_ctl [1:7];
        logic [1:0] exp_st  [1:7];
        int         we0;
        exp_ctl = '{3'b111, 3'b011, 3'b001, 3'b001, 3'b011, 3'b111, 3'b111};
        exp_st  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        applyStimulus(16'h0040, 16'hBEEF, 3'b000);
        we0 = we_low_cnt;
        applyStimulus(16'h0040, 16'hBEEF, 3'b011);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.mem_cs_n, bus.mem_we_n, bus.mem_oe_n} !== exp_ctl[k]) begin
                fails++;
                $display("[TB] FAIL write_ctl cycle %0d: got %b, expected %b", k, {bus.mem_cs_n, bus.mem_we_n, bus.mem_oe_n}, exp_ctl[k]);
            end
            checks++;
            if (bus.status_out !== exp_st[k]) begin
                fails++;
                $display("[TB] FAIL write_status cycle %0d: got %b, expected %b", k, bus.status_out, exp_st[k]);
            end
            if (k == 3) begin
                checks++;
                if ({bus.mem_addr, bus.mem_wdata} !== 32'h0040BEEF) begin
                    fails++;
                    $display("[TB] FAIL write_bus: got %h, expected 0040beef", {bus.mem_addr, bus.mem_wdata});
                end
            end
        end
        checks++;
        if (we_low_cnt - we0 != 2) begin
            fails++;
            $display("[TB] FAIL write_we_cycles: got %0d, expected 2", we_low_cnt - we0);
        end
        checks++;
        if (!wr_flag[16'h0040] || sram[16'h0040] !== 16'hBEEF) begin
            fails++;
            $display("[TB] FAIL write_sram: got %h, expected beef", sram[16'h0040]);
        end
    endtask

    task automatic test_read();
        logic [2:0] exp_ctl [1:7];
        logic [1:0] exp_st  [1:7];
        int         we0, oe0;
        exp_ctl = '{3'b111, 3'b011, 3'b010, 3'b010, 3'b011, 3'b111, 3'b111};
        exp_st  = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        applyStimulus(16'h0040, 16'h0000, 3'b000);
        @(negedge clk);
        we0 = we_low_cnt;
        oe0 = oe_low_cnt;
        applyStimulus(16'h0040, 16'h0000, 3'b001);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.mem_cs_n, bus.mem_we_n, bus.mem_oe_n} !== exp_ctl[k]) begin
                fails++;
                $display("[TB] FAIL read_ctl cycle %0d: got %b, expected %b", k, {bus.mem_cs_n, bus.mem_we_n, bus.mem_oe_n}, exp_ctl[k]);
            end
            checks++;
            if (bus.status_out !== exp_st[k]) begin
                fails++;
                $display("[TB] FAIL read_status cycle %0d: got %b, expected %b", k, bus.status_out, exp_st[k]);
            end
            if (k == 4) begin
                checks++;
                if (bus.rdata_out !== 16'h0000) begin
                    fails++;
                    $display("[TB] FAIL read_early: got %h, expected 0000", bus.rdata_out);
                end
            end
            if (k == 5) begin
                checks++;
                if (bus.rdata_out !== 16'hBEEF) begin
                    fails++;
                    $display("[TB] FAIL read_data: got %h, expected beef", bus.rdata_out);
                end
            end
        end
        checks++;
        if (we_low_cnt - we0 != 0 || oe_low_cnt - oe0 != 2) begin
            fails++;
            $display("[TB] FAIL read_strobes: got we %0d oe %0d, expected we 0 oe 2", we_low_cnt - we0, oe_low_cnt - oe0);
        end
    endtask

    task automatic test_back_to_back();
        int cs0, we0, dn0;
        applyStimulus(16'h0080, 16'h1234, 3'b000);
        @(negedge clk);
        cs0 = cs_fall_cnt;
        we0 = we_low_cnt;
        dn0 = done_rise_cnt;
        applyStimulus(16'h0080, 16'h1234, 3'b011);
        repeat (2) @(negedge clk);
        applyStimulus(16'h0099, 16'hDEAD, 3'b010);
        applyStimulus(16'h0099, 16'hDEAD, 3'b011);
        repeat (12) @(negedge clk);
        checks++;
        if (cs_fall_cnt - cs0 != 1 || we_low_cnt - we0 != 2) begin
            fails++;
            $display("[TB] FAIL retrigger_accesses: got cs %0d we %0d, expected cs 1 we 2", cs_fall_cnt - cs0, we_low_cnt - we0);
        end
        checks++;
        if (done_rise_cnt - dn0 != 1 || bus.status_out !== 2'b10) begin
            fails++;
            $display("[TB] FAIL retrigger_done: got rises %0d status %b, expected 1 and 10", done_rise_cnt - dn0, bus.status_out);
        end
        checks++;
        if (sram[16'h0080] !== 16'h1234 || wr_flag[16'h0099]) begin
            fails++;
            $display("[TB] FAIL retrigger_latch: got %h flag99 %0d, expected 1234 flag99 0", sram[16'h0080], wr_flag[16'h0099]);
        end
    endtask

    task automatic test_reset_mid_access();
        applyStimulus(16'h00C0, 16'h5555, 3'b000);
        applyStimulus(16'h00C0, 16'h5555, 3'b011);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.mem_we_n !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_pre: got we_n %b, expected 0", bus.mem_we_n);
        end
        #2;
        reset_n = 1'b0;
        bus.cmd_in = 3'b000;
        #1;
        checks++;
        if ({bus.mem_cs_n, bus.mem_we_n, bus.mem_oe_n, bus.status_out} !== 5'b11100) begin
            fails++;
            $display("[TB] FAIL midreset_async: got %b, expected 11100", {bus.mem_cs_n, bus.mem_we_n, bus.mem_oe_n, bus.status_out});
        end
        checks++;
        if ({bus.rdata_out, bus.mem_addr} !== 32'h0) begin
            fails++;
            $display("[TB] FAIL midreset_regs: got %h, expected 0", {bus.rdata_out, bus.mem_addr});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (wr_flag[16'h00C0]) begin
            fails++;
            $display("[TB] FAIL midreset_partial: got write flag 1, expected 0");
        end
        @(negedge clk);
        applyStimulus(16'h00C0, 16'h7777, 3'b011);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.status_out !== 2'b01) begin
            fails++;
            $display("[TB] FAIL midreset_busy: got %b, expected 01", bus.status_out);
        end
        @(negedge clk);
        checks++;
        if (bus.status_out !== 2'b10 || sram[16'h00C0] !== 16'h7777) begin
            fails++;
            $display("[TB] FAIL midreset_clean: got status %b data %h, expected 10 7777", bus.status_out, sram[16'h00C0]);
        end
    endtask

    task automatic test_autoinc();
        logic [15:0] exp_addr [0:3];
        logic        use_ptr;
`ifdef PIO_MEM_AUTOINC_EN
        exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
`else
        exp_addr = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
`endif
        for (int i = 0; i < 4; i++) begin
            use_ptr = (i != 0);
            applyStimulus(16'hFFFE, 16'h0000, {use_ptr, 2'b00});
            applyStimulus(16'hFFFE, 16'h0000, {use_ptr, 2'b01});
            repeat (3) @(negedge clk);
            checks++;
            if (bus.mem_oe_n !== 1'b0 || bus.mem_addr !== exp_addr[i]) begin
                fails++;
                $display("[TB] FAIL autoinc_addr %0d: got oe_n %b addr %h, expected 0 %h", i, bus.mem_oe_n, bus.mem_addr, exp_addr[i]);
            end
            repeat (2) @(negedge clk);
            checks++;
            if (bus.rdata_out !== (exp_addr[i] ^ 16'h5A5A)) begin
                fails++;
                $display("[TB] FAIL autoinc_data %0d: got %h, expected %h", i, bus.rdata_out, exp_addr[i] ^ 16'h5A5A);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_status_exclusive();
        checks++;
        if (both_cnt != 0) begin
            fails++;
            $display("[TB] FAIL status_exclusive: got %0d cycles with busy and done, expected 0", both_cnt);
        end
    endtask

    initial begin
        bus.addr_in  = '0;
        bus.wdata_in = '0;
        bus.cmd_in   = '0;
        reset_n      = 1'b0;
        $display("[TB] starting pio_mem_sequencer tests");
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_access();
        test_autoinc();
        test_status_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
